// File: rtl/abro_pkg.sv
// abro_pkg: shared state and order encodings for the ABRO stimulus sequencer
package abro_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ABRO_S_IDLE   = 3'd0,
    ABRO_S_FIRST  = 3'd1,
    ABRO_S_GAP    = 3'd2,
    ABRO_S_SECOND = 3'd3,
    ABRO_S_WAIT_O = 3'd4,
    ABRO_S_DONE   = 3'd5
  } abro_state_e;
  typedef enum logic [1:0] {
    ORD_AB     = 2'd0,
    ORD_BA     = 2'd1,
    ORD_SIM    = 2'd2,
    ORD_A_ONLY = 2'd3
  } abro_order_e;
endpackage

// File: rtl/abro_cycle_timer.sv
// abro_cycle_timer: loadable up/down cycle counter with a terminal-count flag
module abro_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : en ? (up ? count_q + W'(1) : count_q - W'(1)) : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign tc = count_q == term;
endmodule

// File: rtl/abro_stim_sequencer.sv
// abro_stim_sequencer: emits ordered A/B event pulses into ABRO and grades the O response
module abro_stim_sequencer
  import abro_pkg::*;
#(
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         order,
  input  logic [GAP_W-1:0]   gap,
  output logic               ready,
  output logic               A,
  output logic               B,
  input  logic               O,
  output logic               done,
  output logic               pass,
  output logic [STATE_W-1:0] state
);
  localparam int TW = $clog2(TIMEOUT + 1);
  abro_state_e state_q, state_d;
  abro_order_e order_q, order_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic early_q, early_d, pass_q, pass_d;
  logic gap_tc, wait_tc;
  abro_cycle_timer #(.W(GAP_W)) u_gap_timer (
    .clk(clk), .reset(reset), .load(state_q == ABRO_S_FIRST), .en(state_q == ABRO_S_GAP),
    .up(1'b0), .load_val(gap_q), .term(GAP_W'(1)), .tc(gap_tc)
  );
  abro_cycle_timer #(.W(TW)) u_wait_timer (
    .clk(clk), .reset(reset), .load(state_q != ABRO_S_WAIT_O), .en(1'b1),
    .up(1'b1), .load_val('0), .term(TW'(TIMEOUT - 1)), .tc(wait_tc)
  );
  always_comb begin
    state_d = state_q;
    order_d = order_q;
    gap_d   = gap_q;
    pass_d  = pass_q;
    early_d = early_q | (O & (state_q inside {ABRO_S_FIRST, ABRO_S_GAP, ABRO_S_SECOND}));
    case (state_q)
      ABRO_S_IDLE: if (start) begin
        order_d = abro_order_e'(order);
        gap_d   = gap;
        early_d = 1'b0;
        pass_d  = 1'b0;
        state_d = ABRO_S_FIRST;
      end
      ABRO_S_FIRST:  state_d = (order_q inside {ORD_SIM, ORD_A_ONLY}) ? ABRO_S_WAIT_O :
                               (gap_q != '0) ? ABRO_S_GAP : ABRO_S_SECOND;
      ABRO_S_GAP:    state_d = gap_tc ? ABRO_S_SECOND : ABRO_S_GAP;
      ABRO_S_SECOND: state_d = ABRO_S_WAIT_O;
      ABRO_S_WAIT_O: if (O || wait_tc) begin
        state_d = ABRO_S_DONE;
        pass_d  = (order_q == ORD_A_ONLY) ? !(early_q || O) : (O && !early_q);
      end
      default:       state_d = ABRO_S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ABRO_S_IDLE;
      order_q <= ORD_AB;
      gap_q   <= '0;
      early_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      gap_q   <= gap_d;
      early_q <= early_d;
      pass_q  <= pass_d;
    end
  end
  assign ready = state_q == ABRO_S_IDLE;
  assign A     = (state_q == ABRO_S_FIRST && order_q != ORD_BA) || (state_q == ABRO_S_SECOND && order_q == ORD_BA);
  assign B     = (state_q == ABRO_S_FIRST && order_q inside {ORD_BA, ORD_SIM}) || (state_q == ABRO_S_SECOND && order_q == ORD_AB);
  assign done  = state_q == ABRO_S_DONE;
  assign pass  = pass_q;
  assign state = state_q;
endmodule

// File: tb/tb_abro_stim_sequencer.sv
// tb_abro_stim_sequencer: randomized self-checking bench against a behavioural sequence model
module tb_abro_stim_sequencer;
  localparam int GAP_W   = 4;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic reset, start, A, B, O, ready, done, pass;
  logic [1:0] order;
  logic [GAP_W-1:0] gap;
  logic [2:0] state;
  logic a_seen, b_seen, mdl_clr;
  int mode;
  int errors = 0;
  int checks = 0;
  int od;
  bit op;
  always #5 clk = ~clk;
  abro_stim_sequencer #(.GAP_W(GAP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .order(order), .gap(gap), .ready(ready),
    .A(A), .B(B), .O(O), .done(done), .pass(pass), .state(state)
  );
  always @(posedge clk) begin
    if (mdl_clr) begin
      a_seen <= 1'b0;
      b_seen <= 1'b0;
    end else begin
      a_seen <= a_seen | A;
      b_seen <= b_seen | B;
    end
  end
  assign O = mode == 0 ? (a_seen & b_seen) : mode == 1 ? a_seen : (mode == 2);
  function automatic bit o_at(int c, int m, int t_a, int t_b);
    return m == 0 ? (t_b > 0 && c > (t_a > t_b ? t_a : t_b)) : m == 1 ? (c > t_a) : (m == 2);
  endfunction
  task automatic run_seq(input logic [1:0] ord, input logic [GAP_W-1:0] g, input int m,
                         input bit noise, output int obs_done, output bit obs_pass);
    int t_a, t_b, s, done_c;
    bit early, seen_o, exp_pass;
    t_a = 1;
    t_b = 1;
    if (ord == 2'd0) t_b = 2 + int'(g);
    if (ord == 2'd1) t_a = 2 + int'(g);
    if (ord == 2'd3) t_b = -1;
    s = t_a > t_b ? t_a : t_b;
    early = 1'b0;
    for (int c = 1; c <= s; c++) early |= o_at(c, m, t_a, t_b);
    seen_o = 1'b0;
    done_c = s + TIMEOUT + 1;
    for (int c = s + 1; c <= s + TIMEOUT; c++)
      if (!seen_o && o_at(c, m, t_a, t_b)) begin
        seen_o = 1'b1;
        done_c = c + 1;
      end
    exp_pass = ord == 2'd3 ? (!early && !seen_o) : (seen_o && !early);
    @(negedge clk);
    mode = m;
    mdl_clr = 1'b1;
    @(negedge clk);
    mdl_clr = 1'b0;
    start = 1'b1;
    order = ord;
    gap = g;
    @(negedge clk);
    start = 1'b0;
    obs_done = -1;
    obs_pass = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      checks++;
      if (A !== (c == t_a)) begin
        errors++;
        $display("FAIL a_pulse ord=%0d gap=%0d cycle %0d: got %b want %b", ord, g, c, A, c == t_a);
      end
      checks++;
      if (B !== (c == t_b)) begin
        errors++;
        $display("FAIL b_pulse ord=%0d gap=%0d cycle %0d: got %b want %b", ord, g, c, B, c == t_b);
      end
      checks++;
      if (done !== (c == done_c)) begin
        errors++;
        $display("FAIL done_pulse ord=%0d gap=%0d mode=%0d cycle %0d: got %b want %b", ord, g, m, c, done, c == done_c);
      end
      checks++;
      if (ready !== (c > done_c)) begin
        errors++;
        $display("FAIL ready cycle %0d: got %b want %b", c, ready, c > done_c);
      end
      if (c >= done_c) begin
        checks++;
        if (pass !== exp_pass) begin
          errors++;
          $display("FAIL pass ord=%0d gap=%0d mode=%0d cycle %0d: got %b want %b", ord, g, m, c, pass, exp_pass);
        end
      end
      if (done === 1'b1 && obs_done < 0) begin
        obs_done = c;
        obs_pass = pass;
      end
      start = (noise && c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        order = 2'($urandom);
        gap = GAP_W'($urandom);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    order = 2'd0;
    gap = '0;
    mode = 0;
    mdl_clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++;
    if ({A, B, done, pass} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000", {A, B, done, pass}); end
    reset = 1'b0;
    mdl_clr = 1'b0;
  endtask
  task automatic test_order_ab();
    run_seq(2'd0, 4'd3, 0, 1'b0, od, op);
    checks++;
    if (od !== 7 || op !== 1'b1) begin errors++; $display("FAIL order_ab: got done@%0d pass=%b want done@7 pass=1", od, op); end
  endtask
  task automatic test_order_ba();
    run_seq(2'd1, 4'd0, 0, 1'b0, od, op);
    checks++;
    if (od !== 4 || op !== 1'b1) begin errors++; $display("FAIL order_ba: got done@%0d pass=%b want done@4 pass=1", od, op); end
  endtask
  task automatic test_simultaneous();
    run_seq(2'd2, 4'd5, 0, 1'b0, od, op);
    checks++;
    if (od !== 3 || op !== 1'b1) begin errors++; $display("FAIL simultaneous: got done@%0d pass=%b want done@3 pass=1", od, op); end
  endtask
  task automatic test_a_only();
    run_seq(2'd3, 4'd2, 0, 1'b0, od, op);
    checks++;
    if (od !== TIMEOUT + 2 || op !== 1'b1) begin
      errors++;
      $display("FAIL a_only_timeout: got done@%0d pass=%b want done@%0d pass=1", od, op, TIMEOUT + 2);
    end
    run_seq(2'd3, 4'd0, 1, 1'b0, od, op);
    checks++;
    if (op !== 1'b0) begin errors++; $display("FAIL a_only_fires: got pass=%b want 0", op); end
  endtask
  task automatic test_stuck_o();
    run_seq(2'd0, 4'd2, 2, 1'b0, od, op);
    checks++;
    if (op !== 1'b0) begin errors++; $display("FAIL stuck_o_early: got pass=%b want 0", op); end
  endtask
  task automatic test_timeout();
    run_seq(2'd0, 4'd1, 3, 1'b0, od, op);
    checks++;
    if (od !== TIMEOUT + 4 || op !== 1'b0) begin
      errors++;
      $display("FAIL silent_timeout: got done@%0d pass=%b want done@%0d pass=0", od, op, TIMEOUT + 4);
    end
  endtask
  task automatic test_busy_start();
    run_seq(2'd0, 4'd4, 0, 1'b1, od, op);
    checks++;
    if (od !== 8 || op !== 1'b1) begin errors++; $display("FAIL busy_start: got done@%0d pass=%b want done@8 pass=1", od, op); end
    run_seq(2'd1, 4'd2, 0, 1'b1, od, op);
    checks++;
    if (od !== 6 || op !== 1'b1) begin errors++; $display("FAIL busy_start_ba: got done@%0d pass=%b want done@6 pass=1", od, op); end
  endtask
  task automatic test_reset_mid_gap();
    @(negedge clk);
    mode = 0;
    mdl_clr = 1'b1;
    @(negedge clk);
    mdl_clr = 1'b0;
    start = 1'b1;
    order = 2'd0;
    gap = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL mid_gap_state: got %0d want 2", state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || ready !== 1'b1) begin errors++; $display("FAIL abort_state: got state=%0d ready=%b want 0/1", state, ready); end
    checks++;
    if ({A, B, done, pass} !== 4'b0) begin errors++; $display("FAIL abort_outs: got %b want 0000", {A, B, done, pass}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL abort_quiet %0d: got done=%b state=%0d want 0/0", i, done, state); end
    end
    run_seq(2'd0, 4'd1, 0, 1'b0, od, op);
    checks++;
    if (od !== 5 || op !== 1'b1) begin errors++; $display("FAIL after_abort: got done@%0d pass=%b want done@5 pass=1", od, op); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_seq(2'($urandom), GAP_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), od, op);
  endtask
  initial begin
    test_reset();
    test_order_ab();
    test_order_ba();
    test_simultaneous();
    test_a_only();
    test_stuck_o();
    test_timeout();
    test_busy_start();
    test_reset_mid_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
